pe3x3_row_sched: RTL and testbench

- Sequences one 3x3 convolution plane through the 7-input/3-weight/9-output row PE (`pe3x3`).
- For each output row r it issues three kernel-row passes: fmap row r+k paired with weight row k, for k = 0..2.
- It accumulates the three 9-lane partial-sum vectors and hands the finished row downstream on a valid/ready interface.
- Sits between the fmap/weight SRAM buffers and the output writeback path.

---
 rtl/pe3x3_row_sched_pkg.sv | 20 ++
 rtl/pe3x3_acc.sv | 38 +++
 rtl/pe3x3_row_sched.sv | 152 +++++++++++++++
 tb/tb_pe3x3_row_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe3x3_row_sched_pkg.sv
// Shared constants and the FSM encoding for the 3x3 row-PE scheduler.
// Ports: none. This is a package only.
// Imported by pe3x3_row_sched.
package pe3x3_row_sched_pkg;

   localparam int PKG_IW         = 24;
   localparam int PKG_FW         = 8;
   localparam int PKG_DW         = PKG_IW + PKG_FW;
   localparam int PKG_OUTPUT_NUM = 9;
   localparam int KROWS          = 3;   // kernel rows per output row

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_DRAIN = 3'd2,
      S_OUT   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/pe3x3_acc.sv
// Multi-lane partial-sum accumulator. load_i replaces the stored row with psum_i,
// and add_i adds psum_i to it lane by lane, wrapping in two's complement.
// Ports: clk/rst_n, load_i/add_i (load wins), psum_i lane vector, acc_o stored row.
module pe3x3_acc #(
   parameter int DW    = 32,
   parameter int LANES = 9
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_i,
   input  logic                add_i,
   input  logic [LANES*DW-1:0] psum_i,
   output logic [LANES*DW-1:0] acc_o
);

   logic [LANES*DW-1:0] acc_q;
   logic [LANES*DW-1:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      for (int j = 0; j < LANES; j++) begin
         if (load_i) begin
            acc_d[j*DW +: DW] = psum_i[j*DW +: DW];
         end else if (add_i) begin
            // Per-lane add with no carry into the neighbouring lane.
            acc_d[j*DW +: DW] = acc_q[j*DW +: DW] + psum_i[j*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/pe3x3_row_sched.sv
// Sequences one 3x3 convolution plane through the row PE. For each output row it
// issues three kernel-row reads, accumulates the returned psums and offers the row.
// Ports: start/num_rows/base control, busy/done status, fmap and weight read ports,
//        psum_i from the PE, and the valid/ready output row with its row index.
module pe3x3_row_sched
   import pe3x3_row_sched_pkg::*;
#(
   parameter int IW         = PKG_IW,
   parameter int FW         = PKG_FW,
   parameter int OUTPUT_NUM = PKG_OUTPUT_NUM,
   parameter int AW         = 8,
   parameter int MUL_LAT    = 1,
   localparam int DW        = IW + FW
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_i,
   input  logic [AW-1:0]            num_rows_i,
   input  logic [AW-1:0]            fmap_base_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     fmap_rd_o,
   output logic [AW-1:0]            fmap_addr_o,
   output logic                     wht_rd_o,
   output logic [1:0]               wht_addr_o,
   input  logic [OUTPUT_NUM*DW-1:0] psum_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [OUTPUT_NUM*DW-1:0] out_data_o,
   output logic [AW-1:0]            out_row_o
);

   // One buffer-read cycle plus the PE multiplier stages.
   localparam int L = 1 + MUL_LAT;

   state_t              state_q, state_d;
   logic [AW-1:0]       h_q, h_d;
   logic [AW-1:0]       base_q, base_d;
   logic [AW-1:0]       r_q, r_d;
   logic [1:0]          k_q, k_d;
   logic [L-1:0]        tag_vld_q;
   logic [L-1:0][1:0]   tag_k_q;
   logic                issue;
   logic                out_vld;
   logic                done;
   logic                acc_load;
   logic                acc_add;
   logic [OUTPUT_NUM*DW-1:0] acc;

   // The oldest tag lines up with the psum currently on psum_i.
   assign acc_load = tag_vld_q[L-1] && (tag_k_q[L-1] == 2'd0);
   assign acc_add  = tag_vld_q[L-1] && (tag_k_q[L-1] != 2'd0);

   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      base_d  = base_q;
      r_d     = r_q;
      k_d     = k_q;
      issue   = 1'b0;
      out_vld = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (num_rows_i >= AW'(KROWS)) begin
                  h_d     = num_rows_i;
                  base_d  = fmap_base_i;
                  r_d     = '0;
                  k_d     = '0;
                  state_d = S_ISSUE;
               end else begin
                  // Fewer rows than the kernel height: nothing to compute.
                  state_d = S_DONE;
               end
            end
         end
         S_ISSUE: begin
            issue = 1'b1;
            if (k_q == 2'(KROWS - 1)) begin
               k_d     = '0;
               state_d = S_DRAIN;
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         S_DRAIN: begin
            // Leave once the last kernel row's psum is being folded in this cycle.
            if (tag_vld_q[L-1] && (tag_k_q[L-1] == 2'(KROWS - 1))) begin
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            out_vld = 1'b1;
            if (out_ready_i) begin
               r_d = r_q + AW'(1);
               if ((r_q + AW'(1)) == (h_q - AW'(2))) state_d = S_DONE;
               else                                  state_d = S_ISSUE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         h_q       <= '0;
         base_q    <= '0;
         r_q       <= '0;
         k_q       <= '0;
         tag_vld_q <= '0;
         tag_k_q   <= '0;
      end else begin
         state_q   <= state_d;
         h_q       <= h_d;
         base_q    <= base_d;
         r_q       <= r_d;
         k_q       <= k_d;
         tag_vld_q <= {tag_vld_q[L-2:0], issue};
         tag_k_q   <= {tag_k_q[L-2:0], k_q};
      end
   end

   pe3x3_acc #(
      .DW    (DW),
      .LANES (OUTPUT_NUM)
   ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (acc_load),
      .add_i  (acc_add),
      .psum_i (psum_i),
      .acc_o  (acc)
   );

   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = done;
   assign fmap_rd_o   = issue;
   assign wht_rd_o    = issue;
   // Address arithmetic wraps at 2^AW by construction.
   assign fmap_addr_o = issue ? (base_q + r_q + AW'(k_q)) : '0;
   assign wht_addr_o  = issue ? k_q : 2'd0;
   assign out_valid_o = out_vld;
   assign out_data_o  = out_vld ? acc : '0;
   assign out_row_o   = out_vld ? r_q : '0;

endmodule

// File: tb/tb_pe3x3_row_sched.sv
module tb_pe3x3_row_sched;

   localparam int DW = 32;
   localparam int N  = 9;
   localparam int AW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start_i;
   logic [AW-1:0]   num_rows_i;
   logic [AW-1:0]   fmap_base_i;
   logic            busy_o, done_o, fmap_rd_o, wht_rd_o, out_valid_o, out_ready_i;
   logic [AW-1:0]   fmap_addr_o, out_row_o;
   logic [1:0]      wht_addr_o;
   logic [N*DW-1:0] psum_i, out_data_o;

   always #5 clk = ~clk;

   pe3x3_row_sched dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .num_rows_i  (num_rows_i),
      .fmap_base_i (fmap_base_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .fmap_rd_o   (fmap_rd_o),
      .fmap_addr_o (fmap_addr_o),
      .wht_rd_o    (wht_rd_o),
      .wht_addr_o  (wht_addr_o),
      .psum_i      (psum_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_row_o   (out_row_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // PE model: buffer read stage then one multiplier stage, adder tree combinational.
   int         mode = 0;
   logic       p1_vld, p2_vld;
   logic [1:0] p1_k, p2_k;
   always @(posedge clk) begin
      p1_vld <= wht_rd_o;
      p1_k   <= wht_addr_o;
      p2_vld <= p1_vld;
      p2_k   <= p1_k;
   end
   always_comb begin
      psum_i = '0;
      for (int j = 0; j < N; j++) begin
         if (p2_vld !== 1'b1)  psum_i[j*DW +: DW] = 32'hDEAD_0000 + 32'(j);
         else if (mode == 0)   psum_i[j*DW +: DW] = 32'((int'(p2_k) + 1) * j);
         else if (p2_k == 2'd0) psum_i[j*DW +: DW] = 32'h7FFF_FFFF;
         else if (p2_k == 2'd1) psum_i[j*DW +: DW] = 32'd1;
         else                   psum_i[j*DW +: DW] = 32'd0;
      end
   end

   // Scoreboard.
   typedef struct { logic [AW-1:0] addr; logic [1:0] k; } rd_t;
   typedef struct { logic [AW-1:0] row; logic [N*DW-1:0] data; } row_t;
   rd_t  rd_q[$];
   row_t row_q[$];
   int   done_cnt = 0, rows_seen = 0, reads_seen = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (fmap_rd_o) begin
            reads_seen++;
            if (rd_q.size() == 0) begin
               check("unexpected_read", 1, 0);
            end else begin
               rd_t e;
               e = rd_q.pop_front();
               check("fmap_addr", fmap_addr_o, e.addr);
               check("wht_addr", wht_addr_o, e.k);
               check("wht_rd", wht_rd_o, 1);
            end
         end
         if (out_valid_o && out_ready_i) begin
            rows_seen++;
            if (row_q.size() == 0) begin
               check("unexpected_row", 1, 0);
            end else begin
               row_t e;
               e = row_q.pop_front();
               check("out_row", out_row_o, e.row);
               check("out_data", out_data_o, e.data);
            end
         end
         if (done_o) done_cnt++;
      end
   end

   typedef struct {
      int            h;
      logic [AW-1:0] base;
      int            mode;
      int            stall;      // hold out_ready low 5 cycles on the first row
      int            poke;       // pulse start_i while busy
      int            exp_rows;
      int            exp_reads;
      int            exp_lat;    // start cycle counted as 1; 0 = not checked
      int            exp_done;   // cycle done_o seen, same counting; 0 = not checked
   } vec_t;

   task automatic push_expect(input int h, input logic [AW-1:0] base, input int md);
      for (int r = 0; r < h - 2; r++) begin
         row_t e;
         for (int k = 0; k < 3; k++) begin
            rd_t a;
            a.addr = base + AW'(r) + AW'(k);
            a.k    = 2'(k);
            rd_q.push_back(a);
         end
         e.row = AW'(r);
         for (int j = 0; j < N; j++)
            e.data[j*DW +: DW] = (md == 0) ? 32'(6 * j) : 32'h8000_0000;
         row_q.push_back(e);
      end
   endtask

   task automatic run(input vec_t v);
      int              cyc, lat, dcyc, scnt;
      logic            busy_low;
      logic [N*DW-1:0] hold_d;
      logic [AW-1:0]   hold_r;
      push_expect(v.h, v.base, v.mode);
      mode       = v.mode;
      done_cnt   = 0;
      rows_seen  = 0;
      reads_seen = 0;
      out_ready_i = (v.stall != 0) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      start_i     = 1'b1;
      num_rows_i  = AW'(v.h);
      fmap_base_i = v.base;
      cyc = 1; lat = 0; dcyc = 0; scnt = 0; busy_low = 1'b0;
      hold_d = '0; hold_r = '0;
      while (dcyc == 0 && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         start_i = 1'b0;
         if (v.poke != 0 && cyc == 5) begin
            start_i    = 1'b1;
            num_rows_i = AW'(2);
         end
         if (!busy_o) busy_low = 1'b1;
         if (out_valid_o && lat == 0) lat = cyc;
         if (done_o) dcyc = cyc;
         if (v.stall != 0 && out_valid_o && scnt < 6) begin
            if (scnt == 0) begin
               hold_d = out_data_o;
               hold_r = out_row_o;
            end else begin
               check("stall_data", out_data_o, hold_d);
               check("stall_row", out_row_o, hold_r);
               check("stall_no_rd", fmap_rd_o, 0);
            end
            scnt++;
            if (scnt == 6) out_ready_i = 1'b1;
         end
      end
      check("done_seen", (dcyc != 0), 1);
      repeat (3) begin @(posedge clk); #1; end
      check("done_count", done_cnt, 1);
      check("rows_seen", rows_seen, v.exp_rows);
      check("reads_seen", reads_seen, v.exp_reads);
      check("rd_q_empty", rd_q.size(), 0);
      check("row_q_empty", row_q.size(), 0);
      check("busy_end", busy_o, 0);
      check("busy_held", busy_low, 0);
      if (v.exp_lat != 0)  check("latency", lat, v.exp_lat);
      if (v.exp_done != 0) check("done_cycle", dcyc, v.exp_done);
      rd_q.delete();
      row_q.delete();
   endtask

   vec_t tbl[5];

   initial begin
      tbl[0] = '{h:3, base:8'h10, mode:0, stall:0, poke:0, exp_rows:1, exp_reads:3, exp_lat:7, exp_done:8};
      tbl[1] = '{h:5, base:8'h20, mode:0, stall:0, poke:1, exp_rows:3, exp_reads:9, exp_lat:7, exp_done:20};
      tbl[2] = '{h:4, base:8'hFE, mode:1, stall:0, poke:0, exp_rows:2, exp_reads:6, exp_lat:7, exp_done:14};
      tbl[3] = '{h:2, base:8'h40, mode:0, stall:0, poke:0, exp_rows:0, exp_reads:0, exp_lat:0, exp_done:2};
      tbl[4] = '{h:4, base:8'h30, mode:0, stall:1, poke:0, exp_rows:2, exp_reads:6, exp_lat:7, exp_done:0};

      rst_n = 1'b0; start_i = 1'b0; num_rows_i = '0; fmap_base_i = '0; out_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_rd", {fmap_rd_o, wht_rd_o}, 0);
      check("rst_addr", {fmap_addr_o, wht_addr_o}, 0);
      check("rst_out", {out_valid_o, out_row_o, out_data_o}, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run(tbl[i]);

      // Reset in the middle of the ISSUE phase aborts the plane without done_o.
      begin
         int n;
         push_expect(5, 8'h50, 0);
         mode = 0; done_cnt = 0; out_ready_i = 1'b1;
         @(posedge clk); #1;
         start_i = 1'b1; num_rows_i = AW'(5); fmap_base_i = 8'h50;
         @(posedge clk); #1;
         start_i = 1'b0;
         n = 0;
         while (!fmap_rd_o && n < 20) begin @(posedge clk); #1; n++; end
         check("abort_reached_issue", fmap_rd_o, 1);
         @(posedge clk); #1;
         rst_n = 1'b0;
         #1;
         check("abort_busy", busy_o, 0);
         check("abort_rd", {fmap_rd_o, wht_rd_o}, 0);
         check("abort_addr", {fmap_addr_o, wht_addr_o}, 0);
         check("abort_out", {out_valid_o, done_o}, 0);
         rd_q.delete();
         row_q.delete();
         repeat (2) @(posedge clk);
         #1;
         rst_n = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         check("abort_no_done", done_cnt, 0);
         run('{h:3, base:8'h60, mode:0, stall:0, poke:0, exp_rows:1, exp_reads:3, exp_lat:7, exp_done:8});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
